// File: rtl/mod_addsub_pipe_pkg.sv
// Shared GF(p) field definitions for the add/sub datapath.
// Holds the op encodings and the default field width and modulus.
`ifndef BW_GF
`define BW_GF 8
`endif
`ifndef PRIME
`define PRIME 251
`endif

package mod_addsub_pipe_pkg;

    localparam int unsigned GF_BW = `BW_GF;
    localparam logic [`BW_GF-1:0] GF_PRIME = `BW_GF'(`PRIME);

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_NEG  = 2'd2;
    localparam logic [1:0] OP_PASS = 2'd3;

endpackage

// File: rtl/mod_addsub_lane.sv
// One lane of the modular add/sub: the raw (BW+1)-bit value for stage 1 and
// the conditional-subtract reduction applied to the registered raw value.
module mod_addsub_lane
    import mod_addsub_pipe_pkg::*;
#(
    parameter int unsigned     BW    = GF_BW,
    parameter logic [BW-1:0]   PRIME = BW'(GF_PRIME)
) (
    input  logic [1:0]    op_i,
    input  logic [BW-1:0] a_i,
    input  logic [BW-1:0] b_i,
    output logic [BW:0]   raw_o,
    input  logic [BW:0]   raw_i,
    output logic [BW-1:0] res_o
);

    logic [BW:0] a_x;
    logic [BW:0] b_x;
    logic [BW:0] p_x;

    assign a_x = {1'b0, a_i};
    assign b_x = {1'b0, b_i};
    assign p_x = {1'b0, PRIME};

    // With in-range operands every raw value lies in [0, 2p-1], so one
    // conditional subtract is an exact reduction.
    always_comb begin
        raw_o = a_x;
        case (op_i)
            OP_ADD:  raw_o = a_x + b_x;
            OP_SUB:  raw_o = a_x + (p_x - b_x);
            OP_NEG:  raw_o = p_x - b_x;
            default: raw_o = a_x;
        endcase
    end

    assign res_o = (raw_i >= p_x) ? BW'(raw_i - p_x) : raw_i[BW-1:0];

endmodule

// File: rtl/mod_addsub_pipe.sv
// Multi-lane two-stage pipelined modular adder/subtractor over GF(p) with
// valid/ready on both sides and a pass-through tag.
module mod_addsub_pipe
    import mod_addsub_pipe_pkg::*;
#(
    parameter int unsigned        BW_GF = GF_BW,
    parameter logic [BW_GF-1:0]   PRIME = BW_GF'(GF_PRIME),
    parameter int unsigned        LANES = 1,
    parameter int unsigned        TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*LANES-1:0]       in_op,
    input  logic [BW_GF*LANES-1:0]   in_a,
    input  logic [BW_GF*LANES-1:0]   in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BW_GF*LANES-1:0]   out_res,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int unsigned RW = BW_GF + 1;

    logic                     s1_valid_q, s1_valid_d;
    logic [RW*LANES-1:0]      s1_raw_q, s1_raw_d;
    logic [TAG_W-1:0]         s1_tag_q, s1_tag_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [BW_GF*LANES-1:0]   s2_res_q, s2_res_d;
    logic [TAG_W-1:0]         s2_tag_q, s2_tag_d;

    logic [RW*LANES-1:0]      raw_c;
    logic [BW_GF*LANES-1:0]   res_c;
    logic                     s1_adv;
    logic                     s2_adv;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mod_addsub_lane #(
            .BW    (BW_GF),
            .PRIME (PRIME)
        ) u_lane (
            .op_i  (in_op[2*i +: 2]),
            .a_i   (in_a[BW_GF*i +: BW_GF]),
            .b_i   (in_b[BW_GF*i +: BW_GF]),
            .raw_o (raw_c[RW*i +: RW]),
            .raw_i (s1_raw_q[RW*i +: RW]),
            .res_o (res_c[BW_GF*i +: BW_GF])
        );
    end

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // A stage advances when it is empty or the stage after it advances, so
    // ready ripples combinationally back from out_ready (no skid buffer).
    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        s1_valid_d = s1_valid_q;
        s1_raw_d   = s1_raw_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_tag_d   = s2_tag_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_raw_d = raw_c;
                s1_tag_d = in_tag;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d = res_c;
                s2_tag_d = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_raw_q   <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_raw_q   <= s1_raw_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    // Reset wins over capture, so advertising ready during reset is harmless.
    assign in_ready  = s1_adv | rst;
    assign out_valid = s2_valid_q;
    assign out_res   = s2_res_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: doc/mod_addsub_pipe.md
Name: mod_addsub_pipe

Overview:
Multi-lane, two-stage pipelined modular adder/subtractor over GF(p), with ops add, sub, negate and pass.
- Valid/ready handshake on input and output, with full backpressure.
- A tag passes through unchanged, so upstream schedulers can match results to requests.
- Sits between the operand scheduler and the field multipliers/accumulators in the field-arithmetic datapath.
- Supersedes the fixed-latency, enable-only adder; the reduction is exact for every result in [0, 2p-1].

Parameters:
BW_GF, `BW_GF, operand/result width in bits.
PRIME, `PRIME, field modulus; 2 <= PRIME < 2^BW_GF.
LANES, 1, number of independent lanes sharing one handshake.
TAG_W, 4, width of the pass-through tag (>= 1).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input transaction present.
in_ready  out  1  block accepts the input this cycle.
in_op  in  2*LANES  per-lane op, lane i at [2i+1:2i]: 00 ADD, 01 SUB, 10 NEG, 11 PASS.
in_a  in  BW_GF*LANES  per-lane operand a, lane i at [BW_GF*i +: BW_GF].
in_b  in  BW_GF*LANES  per-lane operand b.
in_tag  in  TAG_W  transaction tag.
out_valid  out  1  result present.
out_ready  in  1  downstream accepts the result.
out_res  out  BW_GF*LANES  per-lane result.
out_tag  out  TAG_W  tag of the result.

Behaviour:
- Transfer rule: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stage 1 (S1) registers a (BW_GF+1)-bit raw value per lane, plus the tag and s1_valid:
  - ADD: a+b
  - SUB: a+(PRIME-b)
  - NEG: PRIME-b
  - PASS: a
- Stage 2 (S2) registers per lane res = (raw >= PRIME) ? raw-PRIME : raw, truncated to BW_GF bits, plus the tag and s2_valid.
  - The comparison is >=, so a raw value equal to PRIME yields 0.
- out_valid = s2_valid. out_res and out_tag are driven directly from S2 registers.
- Advance logic:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - The combinational ready path is allowed; there is no skid buffer.
- Latency and throughput:
  - With no backpressure, a result appears 2 cycles after acceptance.
  - Throughput is 1 transaction/cycle.
- Stall: while out_valid && !out_ready, S2 holds its contents stable (out_res and out_tag do not change). S1 fills if it is empty and then holds; in_ready falls once both stages are occupied.
- Bubbles collapse: an empty S2 accepts from S1 regardless of out_ready.
- Ordering is strictly in-order. No transaction is dropped or duplicated.
- Operand domain:
  - Operands must lie in [0, PRIME-1]. Results are then exact for all ops, including b=0 for SUB (result a) and NEG (result 0).
  - Out-of-range operands produce an unspecified value; it is never X, the handshake is unaffected, and the bench does not check it.
- Lanes are fully independent in data and op, and share valid/ready/tag.
- Reset:
  - When rst=1 at a clock edge, s1_valid and s2_valid go to 0 and all data/tag registers clear to 0, so out_res and out_tag read 0.
  - While rst is high, in_ready = 1, but nothing is accepted: rst overrides capture.
  - Reset mid-flight discards all in-flight transactions.
- Simultaneous in/out transfer with both stages full: all stages shift and occupancy stays at 2.

Decomposition:
- Shared field package holds:
  - the op encodings (OP_ADD=2'd0, OP_SUB=2'd1, OP_NEG=2'd2, OP_PASS=2'd3);
  - BW_GF and PRIME defaults alongside the existing `BW_GF / `PRIME macros.
- One sub-module is natural: mod_addsub_lane. It is the purely combinational per-lane raw computation plus the conditional-subtract function, instantiated LANES times.
- The top module owns the valid/ready pipeline control and the tag registers.

Test Plan:
All scenarios use BW_GF=8, PRIME=251, LANES=2, TAG_W=4, unless stated otherwise.
1. ADD, no backpressure: lane0 ADD 200+100, lane1 ADD 250+1, tag 3 -> after 2 cycles out_res lanes = {49, 0}, tag 3, out_valid for 1 cycle.
2. SUB/NEG/PASS: lane0 SUB 5-10, lane1 NEG b=0 -> {246, 0}. Then lane0 SUB 7-0, lane1 PASS a=250 -> {7, 250}.
3. Backpressure: out_ready=0, send tags 1,2,3 back-to-back -> tags 1 and 2 accepted, in_ready=0 on the third attempt, out_tag=1 stable. Then out_ready=1 -> tags 1,2,3 emerge in order with no gap after release.
4. Streaming: 64 random in-range transactions, random in_valid/out_ready at 50% -> every result matches the (a op b) mod 251 reference model, in order, with no loss or duplication.
5. Reset mid-flight: two transactions in flight, rst=1 for 1 cycle -> next cycle out_valid=0, out_res=0, in_ready=1; neither transaction ever appears; a new transaction then completes in 2 cycles.
6. Wide config BW_GF=256, PRIME=2^255-19, LANES=1: ADD (PRIME-1)+(PRIME-1) -> PRIME-2; SUB 0-1 -> PRIME-1.
